// File: rtl/branch_resolve_ctrl_if.sv
// Branch-resolve bus: ID allocation, result broadcast snoop, and resolve/redirect to fetch.
// master = ID/fetch side, slave = branch_resolve_ctrl.
interface branch_resolve_ctrl_if #(
  parameter int DEPTH      = 4,
  parameter int RSID_WIDTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [2:0]            alloc_kind;
  logic                  alloc_pred_taken;
  logic [31:0]           alloc_target;
  logic [31:0]           alloc_fallthrough;
  logic                  alloc_op1_rsid;
  logic                  alloc_op2_rsid;
  logic [31:0]           alloc_op1;
  logic [31:0]           alloc_op2;
  logic                  cdb_valid;
  logic [RSID_WIDTH-1:0] cdb_rsid;
  logic [31:0]           cdb_data;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  flush;
  logic [CW-1:0]         pending_count;
  logic [31:0]           stat_resolved;
  logic [31:0]           stat_mispredict;

  modport master (
    output alloc_valid, alloc_kind, alloc_pred_taken, alloc_target, alloc_fallthrough,
           alloc_op1_rsid, alloc_op2_rsid, alloc_op1, alloc_op2,
           cdb_valid, cdb_rsid, cdb_data,
    input  alloc_ready, resolve_valid, resolve_taken, redirect_valid, redirect_pc,
           flush, pending_count, stat_resolved, stat_mispredict
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_pred_taken, alloc_target, alloc_fallthrough,
           alloc_op1_rsid, alloc_op2_rsid, alloc_op1, alloc_op2,
           cdb_valid, cdb_rsid, cdb_data,
    output alloc_ready, resolve_valid, resolve_taken, redirect_valid, redirect_pc,
           flush, pending_count, stat_resolved, stat_mispredict
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order pending-branch queue: snoops the CDB for missing operands, resolves the head, redirects fetch.
// Optional BRANCH_RESOLVE_STAT_EN adds saturating resolve/mispredict counters (tied to 0 otherwise).
module branch_resolve_slot #(
  parameter int RSID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  clr,
  input  logic [2:0]            a_kind,
  input  logic                  a_pred,
  input  logic [31:0]           a_target,
  input  logic [31:0]           a_fall,
  input  logic                  a_t1,
  input  logic                  a_t2,
  input  logic [31:0]           a_op1,
  input  logic [31:0]           a_op2,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [31:0]           cdb_data,
  output logic                  ready,
  output logic [2:0]            kind,
  output logic                  pred,
  output logic [31:0]           target,
  output logic [31:0]           fall,
  output logic [31:0]           op1,
  output logic [31:0]           op2
);
  logic vld, t1, t2;
  logic a_t2_eff, byp1, byp2, hit1, hit2;

  // only BEQ/BNE compare against a second operand
  assign a_t2_eff = a_t2 && (a_kind <= 3'd1);
  assign byp1     = a_t1 && cdb_valid && (a_op1[RSID_WIDTH-1:0] == cdb_rsid);
  assign byp2     = a_t2_eff && cdb_valid && (a_op2[RSID_WIDTH-1:0] == cdb_rsid);
  assign hit1     = vld && t1 && cdb_valid && (op1[RSID_WIDTH-1:0] == cdb_rsid);
  assign hit2     = vld && t2 && cdb_valid && (op2[RSID_WIDTH-1:0] == cdb_rsid);
  assign ready    = vld && !t1 && !t2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      t1  <= 1'b0;
      t2  <= 1'b0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (wr) begin
      vld <= 1'b1;
      t1  <= a_t1 && !byp1;
      t2  <= a_t2_eff && !byp2;
    end else begin
      if (hit1) t1 <= 1'b0;
      if (hit2) t2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      kind   <= a_kind;
      pred   <= a_pred;
      target <= a_target;
      fall   <= a_fall;
      op1    <= byp1 ? cdb_data : a_op1;
      op2    <= byp2 ? cdb_data : a_op2;
    end else begin
      if (hit1) op1 <= cdb_data;
      if (hit2) op2 <= cdb_data;
    end
  end
endmodule

module branch_resolve_ctrl #(
  parameter int DEPTH      = 4,
  parameter int RSID_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  branch_resolve_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]              head, tail;
  logic [PW:0]                count;
  logic [DEPTH-1:0]           s_ready, s_pred;
  logic [DEPTH-1:0][2:0]      s_kind;
  logic [DEPTH-1:0][31:0]     s_target, s_fall, s_op1, s_op2;
  logic [2:0]                 h_kind;
  logic                       h_pred, taken, mis, res_go, mis_now, alloc_fire;
  logic [31:0]                h_target, h_fall, h_op1, h_op2;

  assign bus.alloc_ready   = !rst && (count != (PW+1)'(DEPTH)) && !mis_now;
  assign alloc_fire        = bus.alloc_valid && bus.alloc_ready;
  assign bus.pending_count = count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    branch_resolve_slot #(.RSID_WIDTH(RSID_WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr       (alloc_fire && (tail == PW'(i))),
      .clr      (mis_now || (res_go && (head == PW'(i)))),
      .a_kind   (bus.alloc_kind),
      .a_pred   (bus.alloc_pred_taken),
      .a_target (bus.alloc_target),
      .a_fall   (bus.alloc_fallthrough),
      .a_t1     (bus.alloc_op1_rsid),
      .a_t2     (bus.alloc_op2_rsid),
      .a_op1    (bus.alloc_op1),
      .a_op2    (bus.alloc_op2),
      .cdb_valid(bus.cdb_valid),
      .cdb_rsid (bus.cdb_rsid),
      .cdb_data (bus.cdb_data),
      .ready    (s_ready[i]),
      .kind     (s_kind[i]),
      .pred     (s_pred[i]),
      .target   (s_target[i]),
      .fall     (s_fall[i]),
      .op1      (s_op1[i]),
      .op2      (s_op2[i])
    );
  end

  assign h_kind   = s_kind[head];
  assign h_pred   = s_pred[head];
  assign h_target = s_target[head];
  assign h_fall   = s_fall[head];
  assign h_op1    = s_op1[head];
  assign h_op2    = s_op2[head];
  assign res_go   = s_ready[head];

  always_comb begin
    taken = 1'b0;
    case (h_kind)
      3'd0:    taken = (h_op1 == h_op2);
      3'd1:    taken = (h_op1 != h_op2);
      3'd2:    taken = ($signed(h_op1) > 32'sd0);
      3'd3:    taken = ($signed(h_op1) <= 32'sd0);
      3'd4:    taken = h_op1[31];
      3'd5:    taken = !h_op1[31];
      3'd6:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // JR checks the predicted target; conditional branches check direction
  assign mis     = (h_kind == 3'd6) ? (h_op1 != h_target) : (taken != h_pred);
  assign mis_now = res_go && mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mis_now) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (res_go)     head <= head + 1'b1;
      if (alloc_fire) tail <= tail + 1'b1;
      count <= count + {{PW{1'b0}}, alloc_fire} - {{PW{1'b0}}, res_go};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.resolve_valid  <= 1'b0;
      bus.resolve_taken  <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.flush          <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.resolve_valid  <= res_go;
      bus.resolve_taken  <= res_go && taken;
      bus.redirect_valid <= mis_now;
      bus.flush          <= mis_now;
      if (mis_now)
        bus.redirect_pc <= (h_kind == 3'd6) ? h_op1 : (taken ? h_target : h_fall);
    end
  end

`ifdef BRANCH_RESOLVE_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stat_resolved   <= '0;
      bus.stat_mispredict <= '0;
    end else begin
      if (res_go && (bus.stat_resolved != 32'hFFFF_FFFF))
        bus.stat_resolved <= bus.stat_resolved + 32'd1;
      if (mis_now && (bus.stat_mispredict != 32'hFFFF_FFFF))
        bus.stat_mispredict <= bus.stat_mispredict + 32'd1;
    end
  end
`else
  assign bus.stat_resolved   = '0;
  assign bus.stat_mispredict = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed scenarios plus randomized traffic
// checked against a queue-level reference model of in-order resolution and flush.
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 4;
  localparam int RW    = 4;

  typedef struct {
    logic [2:0]    kind;
    logic          pred;
    logic [31:0]   tgt, ft;
    logic          t1, t2;
    logic [RW-1:0] g1, g2;
    logic [31:0]   v1, v2;
  } br_t;

  typedef struct {
    logic        taken;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.DEPTH(DEPTH), .RSID_WIDTH(RW)) bus ();
  branch_resolve_ctrl #(.DEPTH(DEPTH), .RSID_WIDTH(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  int          n_res  = 0;
  int          n_mis  = 0;
  logic [31:0] last_pc = 32'h0;
  exp_t        exp_q[$];
  logic        tag_out [1<<RW];
  logic [31:0] tag_val [1<<RW];
  br_t         nil;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input br_t b);
    exp_t e;
    logic signed [31:0] s;
    s = b.v1;
    case (b.kind)
      3'd0:    e.taken = (b.v1 == b.v2);
      3'd1:    e.taken = (b.v1 != b.v2);
      3'd2:    e.taken = (s > 0);
      3'd3:    e.taken = (s <= 0);
      3'd4:    e.taken = (s < 0);
      3'd5:    e.taken = (s >= 0);
      3'd6:    e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    if (b.kind == 3'd6) begin
      e.mis = (b.v1 != b.tgt);
      e.pc  = b.v1;
    end else begin
      e.mis = (e.taken != b.pred);
      e.pc  = e.taken ? b.tgt : b.ft;
    end
    return e;
  endfunction

  function automatic br_t mk(input logic [2:0] kind, input logic pred, input logic [31:0] tgt,
                             input logic [31:0] ft, input logic t1, input logic [RW-1:0] g1,
                             input logic [31:0] v1, input logic t2, input logic [RW-1:0] g2,
                             input logic [31:0] v2);
    br_t b;
    b.kind = kind; b.pred = pred; b.tgt = tgt; b.ft = ft;
    b.t1 = t1; b.g1 = g1; b.v1 = v1; b.t2 = t2; b.g2 = g2; b.v2 = v2;
    return b;
  endfunction

  // drive one cycle of inputs; an accepted allocation enqueues its expected outcome
  task automatic drive_cycle(input br_t b, input logic av, input logic cv,
                             input logic [RW-1:0] ct, input logic [31:0] cd);
    logic [31:0] o1, o2;
    @(posedge clk); #2;
    o1 = $urandom; o2 = $urandom;
    if (b.t1) o1[RW-1:0] = b.g1; else o1 = b.v1;
    if (b.t2) o2[RW-1:0] = b.g2; else o2 = b.v2;
    bus.alloc_valid       = av;
    bus.alloc_kind        = b.kind;
    bus.alloc_pred_taken  = b.pred;
    bus.alloc_target      = b.tgt;
    bus.alloc_fallthrough = b.ft;
    bus.alloc_op1_rsid    = b.t1;
    bus.alloc_op2_rsid    = b.t2;
    bus.alloc_op1         = o1;
    bus.alloc_op2         = o2;
    bus.cdb_valid         = cv;
    bus.cdb_rsid          = ct;
    bus.cdb_data          = cd;
    #1;
    if (av && bus.alloc_ready) exp_q.push_back(model(b));
  endtask

  task automatic idle();
    drive_cycle(nil, 1'b0, 1'b0, '0, 32'h0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h5;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h8000_0000;
      5:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(input logic cv, input logic [RW-1:0] ct, input logic [31:0] cd,
                         output logic t, output logic [RW-1:0] g, output logic [31:0] v);
    t = 1'($urandom_range(0, 1));
    g = RW'($urandom);
    v = rand_val();
    if (t) begin
      if (cv && g == ct)   v = cd;
      else if (tag_out[g]) v = tag_val[g];
      else begin
        tag_out[g] = 1'b1;
        tag_val[g] = v;
      end
    end
  endtask

  function automatic bit any_out();
    for (int i = 0; i < (1<<RW); i++) if (tag_out[i]) return 1'b1;
    return 1'b0;
  endfunction

  // monitor: every reported resolution is matched against the oldest expected one
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (bus.resolve_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_resolve: got resolve_valid=1 expected no pending branch (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            n_res++;
            check("resolve_taken", 32'(bus.resolve_taken), 32'(e.taken));
            check("redirect_valid", 32'(bus.redirect_valid), 32'(e.mis));
            check("flush", 32'(bus.flush), 32'(e.mis));
            if (e.mis) begin
              check("redirect_pc", bus.redirect_pc, e.pc);
              last_pc = e.pc;
              n_mis++;
              exp_q.delete();
            end else begin
              check("redirect_pc_hold", bus.redirect_pc, last_pc);
            end
          end
        end else begin
          check("idle_redirect_flush", {30'h0, bus.redirect_valid, bus.flush}, 32'h0);
        end
      end
    end
  end

  initial begin
    logic          cv, av;
    logic [RW-1:0] ct;
    logic [31:0]   cd;
    br_t           b;
    exp_t          e;
    nil = mk(3'd0, 1'b0, 32'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0, '0, 32'h0);
    for (int i = 0; i < (1<<RW); i++) begin tag_out[i] = 1'b0; tag_val[i] = 32'h0; end
    bus.alloc_valid = 1'b0; bus.alloc_kind = 3'd0; bus.alloc_pred_taken = 1'b0;
    bus.alloc_target = 32'h0; bus.alloc_fallthrough = 32'h0;
    bus.alloc_op1_rsid = 1'b0; bus.alloc_op2_rsid = 1'b0;
    bus.alloc_op1 = 32'h0; bus.alloc_op2 = 32'h0;
    bus.cdb_valid = 1'b0; bus.cdb_rsid = '0; bus.cdb_data = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_resolve_valid", 32'(bus.resolve_valid), 32'h0);
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_redirect_pc", bus.redirect_pc, 32'h0);
    check("rst_pending", 32'(bus.pending_count), 32'h0);
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'h0);
    @(negedge clk); rst = 1'b0;
    idle();
    check("idle_alloc_ready", 32'(bus.alloc_ready), 32'h1);
    check("idle_pending", 32'(bus.pending_count), 32'h0);

    // BEQ waiting on tag 3, value arrives the next cycle
    drive_cycle(mk(3'd0, 1'b0, 32'h100, 32'h20, 1'b1, 4'd3, 32'h5, 1'b0, '0, 32'h5), 1'b1, 1'b0, '0, 32'h0);
    drive_cycle(nil, 1'b0, 1'b1, 4'd3, 32'h5);
    check("beq_pending", 32'(bus.pending_count), 32'h1);
    idle();
    check("beq_not_early", 32'(bus.resolve_valid), 32'h0);
    idle();
    check("beq_resolve", 32'(bus.resolve_valid), 32'h1);
    check("beq_taken", 32'(bus.resolve_taken), 32'h1);
    check("beq_redirect", 32'(bus.redirect_valid), 32'h1);
    check("beq_pc", bus.redirect_pc, 32'h100);
    check("beq_pending_after", 32'(bus.pending_count), 32'h0);

    // JR with same-cycle bypass, correctly predicted
    drive_cycle(mk(3'd6, 1'b1, 32'h400, 32'h44, 1'b1, 4'd2, 32'h400, 1'b0, '0, 32'h0), 1'b1, 1'b1, 4'd2, 32'h400);
    idle();
    check("jr_not_early", 32'(bus.resolve_valid), 32'h0);
    idle();
    check("jr_resolve", 32'(bus.resolve_valid), 32'h1);
    check("jr_no_redirect", 32'(bus.redirect_valid), 32'h0);
    check("jr_pc_hold", bus.redirect_pc, 32'h100);

    // fill with four BNEs, release tags youngest first
    for (int i = 0; i < 4; i++)
      drive_cycle(mk(3'd1, 1'(i % 2 == 0), 32'(32'h500 + i), 32'(32'h600 + i), 1'b1, RW'(4 + i),
                     32'(16 + i), 1'b0, '0, (i % 2 == 1) ? 32'(16 + i) : 32'h0),
                  1'b1, 1'b0, '0, 32'h0);
    for (int i = 3; i >= 0; i--) begin
      drive_cycle(nil, 1'b0, 1'b1, RW'(4 + i), 32'(16 + i));
      check("full_alloc_ready", 32'(bus.alloc_ready), 32'h0);
      check("full_pending", 32'(bus.pending_count), 32'h4);
      check("full_no_resolve", 32'(bus.resolve_valid), 32'h0);
    end
    idle();
    check("full_pop_alloc_ready", 32'(bus.alloc_ready), 32'h0);
    check("full_head_ready_pending", 32'(bus.pending_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("b2b_resolve", 32'(bus.resolve_valid), 32'h1);
      check("b2b_taken", 32'(bus.resolve_taken), 32'(i % 2 == 0));
    end
    idle();
    check("b2b_done", 32'(bus.resolve_valid), 32'h0);
    check("b2b_pending", 32'(bus.pending_count), 32'h0);

    // head BGTZ mispredicts with two younger ready entries and a colliding allocation
    drive_cycle(mk(3'd2, 1'b1, 32'h4000, 32'h3000, 1'b1, 4'd8, 32'hFFFF_FFFF, 1'b0, '0, 32'h0), 1'b1, 1'b0, '0, 32'h0);
    drive_cycle(mk(3'd0, 1'b1, 32'h7000, 32'h7004, 1'b0, '0, 32'h1, 1'b0, '0, 32'h1), 1'b1, 1'b0, '0, 32'h0);
    drive_cycle(mk(3'd0, 1'b1, 32'h7100, 32'h7104, 1'b0, '0, 32'h2, 1'b0, '0, 32'h2), 1'b1, 1'b0, '0, 32'h0);
    drive_cycle(nil, 1'b0, 1'b1, 4'd8, 32'hFFFF_FFFF);
    drive_cycle(mk(3'd0, 1'b0, 32'h7200, 32'h7204, 1'b0, '0, 32'h3, 1'b0, '0, 32'h3), 1'b1, 1'b0, '0, 32'h0);
    check("flush_alloc_drop", 32'(bus.alloc_ready), 32'h0);
    idle();
    check("flush_resolve", 32'(bus.resolve_valid), 32'h1);
    check("flush_flag", 32'(bus.flush), 32'h1);
    check("flush_redirect", 32'(bus.redirect_valid), 32'h1);
    check("flush_pc", bus.redirect_pc, 32'h3000);
    check("flush_pending", 32'(bus.pending_count), 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("flush_squashed", 32'(bus.resolve_valid), 32'h0);
    end

    // randomized traffic
    for (int cyc = 0; cyc < 1500; cyc++) begin
      cv = ($urandom_range(0, 2) == 0);
      ct = RW'($urandom);
      cd = $urandom;
      if (cv && tag_out[ct]) begin cd = tag_val[ct]; tag_out[ct] = 1'b0; end
      b.kind = 3'($urandom_range(0, 7));
      b.tgt  = $urandom;
      b.ft   = $urandom;
      rand_op(cv, ct, cd, b.t1, b.g1, b.v1);
      rand_op(cv, ct, cd, b.t2, b.g2, b.v2);
      if (b.kind <= 3'd1 && !b.t2 && $urandom_range(0, 1) == 1) b.v2 = b.v1;
      if (b.kind == 3'd6 && $urandom_range(0, 3) != 0) b.tgt = b.v1;
      b.pred = 1'b0;
      e = model(b);
      b.pred = ($urandom_range(0, 3) != 0) ? e.taken : 1'($urandom_range(0, 1));
      if (b.kind == 3'd6) b.pred = 1'b1;
      av = 1'($urandom_range(0, 1));
      drive_cycle(b, av, cv, ct, cd);
    end

    // drain: broadcast every outstanding tag
    for (int k = 0; k < 200 && (exp_q.size() != 0 || any_out()); k++) begin
      cv = 1'b0; ct = '0; cd = 32'h0;
      for (int t = 0; t < (1<<RW); t++)
        if (!cv && tag_out[t]) begin
          cv = 1'b1; ct = RW'(t); cd = tag_val[t]; tag_out[t] = 1'b0;
        end
      drive_cycle(nil, 1'b0, cv, ct, cd);
    end
    repeat (3) idle();
    check("drain_expected_empty", exp_q.size(), 32'h0);
    check("drain_pending", 32'(bus.pending_count), 32'h0);
`ifdef BRANCH_RESOLVE_STAT_EN
    check("stat_resolved", bus.stat_resolved, n_res);
    check("stat_mispredict", bus.stat_mispredict, n_mis);
`else
    check("stat_resolved_tied", bus.stat_resolved, 32'h0);
    check("stat_mispredict_tied", bus.stat_mispredict, 32'h0);
`endif

    // asynchronous reset in the middle of a resolve pulse with a waiting entry behind it
    drive_cycle(mk(3'd0, 1'b1, 32'h9000, 32'h9004, 1'b0, '0, 32'h7, 1'b0, '0, 32'h7), 1'b1, 1'b0, '0, 32'h0);
    drive_cycle(mk(3'd1, 1'b0, 32'h9100, 32'h9104, 1'b1, 4'd1, 32'h0, 1'b0, '0, 32'h0), 1'b1, 1'b0, '0, 32'h0);
    idle();
    check("pre_rst_resolve", 32'(bus.resolve_valid), 32'h1);
    check("pre_rst_pending", 32'(bus.pending_count), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_resolve", 32'(bus.resolve_valid), 32'h0);
    check("async_rst_pending", 32'(bus.pending_count), 32'h0);
    check("async_rst_alloc_ready", 32'(bus.alloc_ready), 32'h0);
    check("async_rst_pc", bus.redirect_pc, 32'h0);
    exp_q.delete();
    n_res = 0; n_mis = 0; last_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    check("post_rst_alloc_ready", 32'(bus.alloc_ready), 32'h1);
    check("post_rst_stat_resolved", bus.stat_resolved, 32'h0);
    repeat (3) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
